// File: rtl/dphy_hs_serializer.sv
`default_nettype none
// ============================================================================
// Module   : dphy_hs_serializer
// Brief    : D-PHY HS data-lane transmit serializer. Frames each burst as
//            HS-zero, sync byte, payload and trailer; 2 bits/cycle, LSB first.
// Revision : 1.0 - initial release
// ============================================================================
module dphy_hs_serializer #(
    parameter int          ZERO_BYTES  = 4,
    parameter int          TRAIL_BYTES = 2,
    parameter logic [7:0]  SYNC_WORD   = 8'hB8
) (
    input  logic        dphy_clk,
    input  logic        areset_n,
    input  logic        tx_valid,
    input  logic [7:0]  tx_data,
    input  logic        tx_last,
    output logic        tx_ready,
    output logic [1:0]  dout,
    output logic        hs_oe,
    output logic        busy,
    output logic        underrun
);

    localparam int c_CNT_MAX = (ZERO_BYTES > TRAIL_BYTES) ? ZERO_BYTES : TRAIL_BYTES;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_ZERO_LAST  = c_CNT_W'(ZERO_BYTES - 1);
    localparam logic [c_CNT_W-1:0] c_TRAIL_LAST = c_CNT_W'(TRAIL_BYTES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ZERO  = 3'd1,
        S_SYNC  = 3'd2,
        S_DATA  = 3'd3,
        S_TRAIL = 3'd4
    } state_t;

    state_t               r_state;
    logic [1:0]           r_ph;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [7:0]           r_shift;
    logic                 r_last;
    logic [1:0]           r_dout;
    logic                 r_hs_oe;
    logic                 r_busy;
    logic                 r_underrun;

    logic                 w_ph_end;
    logic                 w_ready;

    assign w_ph_end = (r_ph == 2'd3);
    // Ready points: end of the sync byte, or end of a non-final payload byte.
    assign w_ready  = w_ph_end &&
                      ((r_state == S_SYNC) || ((r_state == S_DATA) && !r_last));

    always_ff @(posedge dphy_clk or negedge areset_n) begin
        if (!areset_n) begin
            r_state    <= S_IDLE;
            r_ph       <= 2'd0;
            r_cnt      <= '0;
            r_shift    <= 8'h00;
            r_last     <= 1'b0;
            r_dout     <= 2'b00;
            r_hs_oe    <= 1'b0;
            r_busy     <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (tx_valid) begin
                        r_state <= S_ZERO;
                        r_ph    <= 2'd0;
                        r_cnt   <= '0;
                        r_dout  <= 2'b00;
                        r_hs_oe <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end

                S_ZERO: begin
                    r_ph <= r_ph + 2'd1;
                    if (w_ph_end) begin
                        if (r_cnt == c_ZERO_LAST) begin
                            r_state <= S_SYNC;
                            r_cnt   <= '0;
                            r_shift <= SYNC_WORD;
                            r_dout  <= SYNC_WORD[1:0];
                        end else begin
                            r_cnt <= r_cnt + c_CNT_ONE;
                        end
                    end
                end

                // The shifter always holds the pair on the line in bits [1:0],
                // so bit 1 at phase 3 is the last bit transmitted.
                S_SYNC, S_DATA: begin
                    r_ph <= r_ph + 2'd1;
                    if (!w_ph_end) begin
                        r_shift <= r_shift >> 2;
                        r_dout  <= r_shift[3:2];
                    end else if (w_ready && tx_valid) begin
                        r_state <= S_DATA;
                        r_shift <= tx_data;
                        r_last  <= tx_last;
                        r_dout  <= tx_data[1:0];
                    end else begin
                        r_state    <= S_TRAIL;
                        r_cnt      <= '0;
                        r_dout     <= {2{~r_shift[1]}};
                        r_underrun <= w_ready;
                    end
                end

                S_TRAIL: begin
                    r_ph <= r_ph + 2'd1;
                    if (w_ph_end) begin
                        if (r_cnt == c_TRAIL_LAST) begin
                            r_state <= S_IDLE;
                            r_cnt   <= '0;
                            r_dout  <= 2'b00;
                            r_hs_oe <= 1'b0;
                            r_busy  <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + c_CNT_ONE;
                        end
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_ph    <= 2'd0;
                    r_dout  <= 2'b00;
                    r_hs_oe <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign tx_ready = w_ready;
    assign dout     = r_dout;
    assign hs_oe    = r_hs_oe;
    assign busy     = r_busy;
    assign underrun = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_dphy_hs_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dphy_hs_serializer
// Brief    : Scoreboard bench for dphy_hs_serializer burst framing.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dphy_hs_serializer;

    localparam int         ZB = 4;
    localparam int         TB = 2;
    localparam logic [7:0] SW = 8'hB8;

    logic       dphy_clk = 1'b0;
    logic       areset_n = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_last  = 1'b0;
    logic       tx_ready;
    logic [1:0] dout;
    logic       hs_oe;
    logic       busy;
    logic       underrun;

    dphy_hs_serializer #(
        .ZERO_BYTES  (ZB),
        .TRAIL_BYTES (TB),
        .SYNC_WORD   (SW)
    ) dut (
        .dphy_clk (dphy_clk),
        .areset_n (areset_n),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_last  (tx_last),
        .tx_ready (tx_ready),
        .dout     (dout),
        .hs_oe    (hs_oe),
        .busy     (busy),
        .underrun (underrun)
    );

    always #5 dphy_clk = ~dphy_clk;

    int         n_vec = 0;
    int         n_err = 0;
    // Each entry: {dout[1:0], hs_oe, busy, tx_ready, underrun}
    logic [5:0] exp_q[$];
    logic [7:0] pay[$];
    logic       lst[$];
    int         drop_after;
    int         idx;
    int         cnt_ready, cnt_ur, cnt_oe;
    int         rdy_cyc[$];
    logic [5:0] got;

    task automatic push_exp(input logic [1:0] d, input logic oe, input logic rdy, input logic ur);
        exp_q.push_back({d, oe, oe, rdy, ur});
    endtask

    task automatic push_idle(input int n);
        repeat (n) push_exp(2'b00, 1'b0, 1'b0, 1'b0);
    endtask

    // Reference framing of one burst, derived from the line protocol.
    task automatic push_burst(input int first, input int nacc, input bit term);
        logic [7:0] sw;
        logic [7:0] b;
        logic       lastbit;
        logic       is_last;
        sw = SW;
        repeat (4 * ZB) push_exp(2'b00, 1'b1, 1'b0, 1'b0);
        for (int p = 0; p < 4; p++) push_exp(sw[2*p +: 2], 1'b1, p == 3, 1'b0);
        lastbit = sw[7];
        for (int k = 0; k < nacc; k++) begin
            b       = pay[first + k];
            is_last = term && (k == nacc - 1);
            for (int p = 0; p < 4; p++) push_exp(b[2*p +: 2], 1'b1, (p == 3) && !is_last, 1'b0);
            lastbit = b[7];
        end
        for (int t = 0; t < 4 * TB; t++) push_exp({2{~lastbit}}, 1'b1, 1'b0, !term && (t == 0));
    endtask

    task automatic set_inputs();
        if (idx < drop_after) begin
            tx_valid = 1'b1;
            tx_data  = pay[idx];
            tx_last  = lst[idx];
        end else begin
            tx_valid = 1'b0;
            tx_data  = 8'($urandom);
            tx_last  = 1'($urandom);
        end
    endtask

    // Source model plus scoreboard drain: one popped entry per cycle.
    task automatic drive_cycles(input string tag, input int n);
        logic acc;
        cnt_ready = 0;
        cnt_ur    = 0;
        cnt_oe    = 0;
        rdy_cyc.delete();
        for (int c = 0; c < n; c++) begin
            @(negedge dphy_clk);
            got = {dout, hs_oe, busy, tx_ready, underrun};
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL %s cycle %0d: scoreboard empty, got %b", tag, c, got);
            end else if (got !== exp_q[0]) begin
                n_err++;
                $display("FAIL %s cycle %0d: {dout,hs_oe,busy,ready,underrun} got %b required %b",
                         tag, c, got, exp_q[0]);
            end
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            if (tx_ready === 1'b1) begin
                cnt_ready++;
                rdy_cyc.push_back(c);
            end
            if (underrun === 1'b1) cnt_ur++;
            if (hs_oe === 1'b1) cnt_oe++;
            acc = tx_ready && tx_valid;
            @(posedge dphy_clk);
            #1;
            if (acc) idx++;
            set_inputs();
        end
    endtask

    task automatic load(input int drop);
        drop_after = drop;
        idx        = 0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        repeat (3) @(posedge dphy_clk);
        #1;
        got = {dout, hs_oe, busy, tx_ready, underrun};
        n_vec++;
        if (got !== 6'b0) begin
            n_err++;
            $display("FAIL reset_values: got %b required %b", got, 6'b0);
        end
        pay.delete();
        lst.delete();
        load(0);
        set_inputs();
        areset_n = 1'b1;
        push_idle(20);
        drive_cycles("idle", exp_q.size());
        n_vec++;
        if (cnt_oe !== 0) begin
            n_err++;
            $display("FAIL idle_hs_oe: high for %0d cycles, required 0", cnt_oe);
        end
    endtask

    task automatic test_single();
        pay = '{8'hA5};
        lst = '{1'b1};
        load(1);
        push_idle(1);
        push_burst(0, 1, 1'b1);
        push_idle(1);
        set_inputs();
        drive_cycles("single", exp_q.size());
        n_vec++;
        if (cnt_oe !== 32) begin
            n_err++;
            $display("FAIL single_hs_oe_len: got %0d required 32", cnt_oe);
        end
    endtask

    task automatic test_multi();
        pay = '{8'h01, 8'h02, 8'hFF};
        lst = '{1'b0, 1'b0, 1'b1};
        load(3);
        push_idle(1);
        push_burst(0, 3, 1'b1);
        push_idle(1);
        set_inputs();
        drive_cycles("multi", exp_q.size());
        n_vec++;
        if (cnt_ready !== 3) begin
            n_err++;
            $display("FAIL multi_ready_count: got %0d required 3", cnt_ready);
        end else begin
            n_vec++;
            if ((rdy_cyc[1] - rdy_cyc[0] !== 4) || (rdy_cyc[2] - rdy_cyc[1] !== 4)) begin
                n_err++;
                $display("FAIL multi_ready_spacing: got %0d,%0d required 4,4",
                         rdy_cyc[1] - rdy_cyc[0], rdy_cyc[2] - rdy_cyc[1]);
            end
        end
    endtask

    task automatic test_underrun();
        pay = '{8'h3C};
        lst = '{1'b0};
        load(1);
        push_idle(1);
        push_burst(0, 1, 1'b0);
        push_idle(2);
        set_inputs();
        drive_cycles("underrun", exp_q.size());
        n_vec++;
        if (cnt_ur !== 1) begin
            n_err++;
            $display("FAIL underrun_pulses: got %0d required 1", cnt_ur);
        end
    endtask

    task automatic test_async_reset();
        pay = '{8'hC3, 8'h7E, 8'h11};
        lst = '{1'b0, 1'b0, 1'b1};
        load(3);
        push_idle(1);
        push_burst(0, 3, 1'b1);
        set_inputs();
        drive_cycles("pre_reset", 1 + 4 * ZB + 4 + 6);
        exp_q.delete();
        #2;
        areset_n = 1'b0;
        #1;
        got = {dout, hs_oe, busy, tx_ready, underrun};
        n_vec++;
        if (got !== 6'b0) begin
            n_err++;
            $display("FAIL async_reset: got %b required %b", got, 6'b0);
        end
        tx_valid = 1'b0;
        @(posedge dphy_clk);
        #1;
        got = {dout, hs_oe, busy, tx_ready, underrun};
        n_vec++;
        if (got !== 6'b0) begin
            n_err++;
            $display("FAIL reset_held: got %b required %b", got, 6'b0);
        end
        areset_n = 1'b1;
        pay = '{8'h7E};
        lst = '{1'b1};
        load(1);
        push_idle(1);
        push_burst(0, 1, 1'b1);
        push_idle(1);
        set_inputs();
        drive_cycles("post_reset", exp_q.size());
        n_vec++;
        if (cnt_oe !== 32) begin
            n_err++;
            $display("FAIL post_reset_hs_oe_len: got %0d required 32", cnt_oe);
        end
    endtask

    task automatic test_back_to_back();
        pay = '{8'hC3, 8'hC3};
        lst = '{1'b1, 1'b1};
        load(2);
        push_idle(1);
        push_burst(0, 1, 1'b1);
        push_idle(1);
        push_burst(1, 1, 1'b1);
        push_idle(1);
        set_inputs();
        drive_cycles("back_to_back", exp_q.size());
        n_vec++;
        if (cnt_oe !== 64) begin
            n_err++;
            $display("FAIL b2b_hs_oe_len: got %0d required 64", cnt_oe);
        end
    endtask

    task automatic test_random();
        pay.delete();
        lst.delete();
        for (int i = 0; i < 4; i++) begin
            pay.push_back(8'($urandom));
            lst.push_back(i == 3);
        end
        load(4);
        push_idle(1);
        push_burst(0, 4, 1'b1);
        push_idle(1);
        set_inputs();
        drive_cycles("random", exp_q.size());
        n_vec++;
        if (cnt_ready !== 4) begin
            n_err++;
            $display("FAIL random_ready_count: got %0d required 4", cnt_ready);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_underrun();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/dphy_hs_serializer.md
# dphy_hs_serializer

High-speed D-PHY data-lane transmit serializer; the transmit counterpart of the lane input deserializer. It takes bytes over a valid/ready handshake and frames each burst as HS-zero, sync byte, payload and trailer. It emits two bits per cycle, LSB first, to an architecture-specific DDR output primitive. It runs entirely in the fast D-PHY DDR clock domain; the byte-side handshake is clocked by the same clock.

## Interface
- `ZERO_BYTES`, 4: HS-zero duration in byte times (4 cycles each); legal range ≥1.
- `TRAIL_BYTES`, 2: HS-trail duration in byte times; legal range ≥1.
- `SYNC_WORD`, 8'hB8: leader sequence sent after HS-zero.
- `dphy_clk` in 1: fast D-PHY DDR clock; 2 line bits per cycle.
- `areset_n` in 1: asynchronous, active-low reset.
- `tx_valid` in 1: byte available; also requests a burst when idle.
- `tx_data` in 8: payload byte; bit 0 is transmitted first.
- `tx_last` in 1: qualifies `tx_data`; marks the final byte of a burst.
- `tx_ready` out 1: byte accepted at an edge where `tx_valid && tx_ready`.
- `dout` out 2: to the DDR primitive; `dout[0]` is sent before `dout[1]`.
- `hs_oe` out 1: HS driver enable; high for the whole burst.
- `busy` out 1: state ≠ IDLE.
- `underrun` out 1: one-cycle pulse when a burst is aborted for lack of data.

## Operation
- States: IDLE, ZERO, SYNC, DATA, TRAIL.
- A 2-bit phase counter `ph` runs 0..3 in every non-IDLE state.
- A byte counter times ZERO and TRAIL.
- `dout`, `hs_oe`, `busy` and `underrun` are registered.
- `tx_ready` is combinational: `ph==3` in SYNC, or in DATA when the current byte is not last. It is low otherwise.

State transitions:
- IDLE → ZERO: on any edge with `tx_valid=1`. No byte is consumed at this edge.
- ZERO: `dout=2'b00` for `4*ZERO_BYTES` cycles, then → SYNC.
- SYNC: shifts `SYNC_WORD` LSB first. With the default `SYNC_WORD` the `dout` sequence is 00, 10, 11, 10.
  - At `ph==3`: if `tx_valid`, accept the byte and go → DATA.
  - Otherwise go → TRAIL and pulse `underrun`.
- DATA: `dout` carries `{b1,b0}`, `{b3,b2}`, `{b5,b4}`, `{b7,b6}` of the accepted byte on consecutive cycles.
  - At `ph==3` with the current byte not last: `tx_valid=1` accepts the next byte with no gap.
  - At `ph==3` with the current byte not last: `tx_valid=0` goes → TRAIL and pulses `underrun`.
  - At `ph==3` with the current byte last: go → TRAIL. `tx_ready` stays low.
- TRAIL: both `dout` bits equal the inverse of the last bit transmitted (b7 of the final byte, or SYNC bit 7). This lasts `4*TRAIL_BYTES` cycles, then → IDLE.
- IDLE outputs: `dout=00`, `hs_oe=0`, `busy=0`.

Boundary conditions:
- `tx_data`/`tx_last` are sampled only at accept edges; their values at other times are ignored.
- `tx_valid` dropping during ZERO/SYNC does not abort the burst. It is examined only at the SYNC ready point.
- Back-to-back bursts: at least one IDLE cycle (`hs_oe=0`) separates them. A new burst starts on the first IDLE edge that sees `tx_valid`.
- `areset_n` low at any time, including mid-burst, immediately forces IDLE with all outputs at reset values. The partial burst is dropped and no trailer is sent.

## Timing
- Reset values: `dout=2'b00`, `hs_oe=0`, `busy=0`, `underrun=0`, `tx_ready=0`.
- Let E0 be the start edge. Cycle k is the cycle after edge E0+k-1.
  - Cycles 1..4Z: ZERO, with `hs_oe=1` from cycle 1.
  - Cycles 4Z+1..4Z+4: SYNC. `tx_ready=1` in cycle 4Z+4.
  - The first payload pair appears in cycle 4Z+5.
- Sustained throughput: one byte per 4 cycles. `tx_ready` is high exactly one cycle in four during DATA.
- Accepted-byte latency: its first pair is on `dout` the cycle after the accept edge.
- Last payload pair in cycle n: trail occupies n+1..n+4T, and `hs_oe=0` from cycle n+4T+1.
- `underrun` is high in the first TRAIL cycle only.

## Test plan
- Reset, then idle 20 cycles: `dout=00`, `hs_oe=0`, `tx_ready=0` throughout; no state change.
- Defaults, 1-byte burst 8'hA5 with `tx_last=1` and `tx_valid` held:
  - `dout`: 16×00, then 00,10,11,10.
  - Then 01,01,10,10 (A5 = 1010_0101, LSB first).
  - Then 8×00, since b7 = 1 and the trail is its inverse.
  - Then `hs_oe` falls: 32 cycles high in total.
- 3-byte burst 01,02,FF:
  - `tx_ready` pulses exactly 3 times, 4 cycles apart.
  - Trail is 8×00 because b7 of FF is 1.
  - No gaps between payload bytes.
- Underrun: deassert `tx_valid` at the second ready point of an unterminated burst.
  - `underrun` pulses once.
  - Trail is the inverse of the first byte's b7.
  - IDLE follows after 8 cycles.
- `areset_n` asserted mid-DATA (between edges): outputs go to reset values asynchronously. After release, a new burst starts cleanly with a full ZERO period.
- Two bursts, with `tx_valid` re-asserted in the first IDLE cycle: exactly one cycle of `hs_oe=0` between them. The second burst's framing is identical to the first.
